// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ifu_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_BUS      = 2'd2,
    FAULT_TIMEOUT  = 2'd3
  } fault_cause_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting on the instruction bus; expired marks the last
// cycle in which a fetch may still complete.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LAST so a stalled state cannot wrap the counter back to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one word read per fetch request and reports
// the word (or a fault) with a single-cycle fetch_done pulse.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [31:0] pc_load_addr,
  output logic        fetch_done,
  output logic [31:0] instruction,
  output logic [31:0] fetch_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output ifu_state_t  dbg_state
);

  // Handshake: a request transfers on a cycle where imem_req_valid and
  // imem_req_ready are both high; valid/addr stay stable until then. A
  // response is a single cycle of imem_rsp_valid, only sampled in WAIT.

  ifu_state_t   state, next_state;
  fault_cause_t done_fault;
  logic [31:0]  fetch_addr, done_instr, done_pc;
  logic         start_req, expired;
  logic         redir_pending;
  logic [31:0]  redir_addr;
  logic         redirect_hit;
  logic [31:0]  redirect_addr;

  assign dbg_state     = state;
  assign redirect_hit  = pc_load || redir_pending;
  assign redirect_addr = pc_load ? pc_load_addr : redir_addr;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (start_req),
    .en     ((state == REQ) || (state == WAIT)),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start_req  = 1'b0;
    done_fault = FAULT_NONE;
    done_instr = '0;
    done_pc    = imem_req_addr;
    fetch_addr = pc_load ? pc_load_addr : pc;
    case (state)
      IDLE: begin
        if (fetch_en) begin
          if (fetch_addr[1:0] != 2'b00) begin
            next_state = DONE;
            done_fault = FAULT_MISALIGN;
            done_pc    = fetch_addr;
          end else begin
            next_state = REQ;
            start_req  = 1'b1;
          end
        end
      end
      REQ: begin
        if (expired) begin
          next_state = DONE;
          done_fault = FAULT_TIMEOUT;
        end else if (imem_req_ready) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the expiry cycle still counts as completion.
        if (imem_rsp_valid) begin
          next_state = DONE;
          if (imem_rsp_err) begin
            done_fault = FAULT_BUS;
          end else begin
            done_instr = imem_rsp_data;
          end
        end else if (expired) begin
          next_state = DONE;
          done_fault = FAULT_TIMEOUT;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_req_valid <= 1'b0;
      imem_req_addr  <= '0;
      fetch_done     <= 1'b0;
      instruction    <= '0;
      fetch_pc       <= '0;
      fetch_fault    <= 1'b0;
      fault_cause    <= FAULT_NONE;
    end else begin
      imem_req_valid <= (next_state == REQ);
      if (start_req) begin
        imem_req_addr <= fetch_addr;
      end
      fetch_done <= (next_state == DONE);
      if (next_state == DONE) begin
        instruction <= done_instr;
        fetch_pc    <= done_pc;
        fetch_fault <= (done_fault != FAULT_NONE);
        fault_cause <= done_fault;
      end
    end
  end

  // PC and pending redirect: the new PC is already visible in the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      redir_pending <= 1'b0;
      redir_addr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc <= pc_load_addr;
          end
        end
        REQ, WAIT: begin
          if (next_state == DONE) begin
            redir_pending <= 1'b0;
            if (redirect_hit) begin
              pc <= redirect_addr;
            end else if (done_fault == FAULT_NONE) begin
              pc <= imem_req_addr + 32'(INSTR_BYTES);
            end
          end else if (pc_load) begin
            redir_pending <= 1'b1;
            redir_addr    <= pc_load_addr;
          end
        end
        DONE: begin
          if (pc_load) begin
            pc <= pc_load_addr;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: vector table, hand-written corner
// sequences and randomized fetches against a transaction-level model.
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en, pc_load;
  logic [31:0] pc_load_addr;
  logic        fetch_done;
  logic [31:0] instruction, fetch_pc, pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  ifu_state_t  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [97:0] exp_q[$];
  logic [31:0] model_pc;

  instruction_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_en      (fetch_en),
    .pc_load       (pc_load),
    .pc_load_addr  (pc_load_addr),
    .fetch_done    (fetch_done),
    .instruction   (instruction),
    .fetch_pc      (fetch_pc),
    .fetch_fault   (fetch_fault),
    .fault_cause   (fault_cause),
    .pc            (pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          load;
    logic [31:0] addr;
    int          rd;
    int          rsp;
    bit          err;
    bit          no_rsp;
    logic [31:0] data;
    bit          redir;
    logic [31:0] raddr;
    logic [31:0] e_instr;
    logic [31:0] e_fpc;
    logic [1:0]  e_cause;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tv[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One fetch: raises fetch_en for a cycle then plays the memory side.
  task automatic do_fetch(input vec_t v);
    int cyc, hold, wcyc, vcnt, lat_exp, v_exp;
    bit accepted, done;
    logic [97:0] rec;
    exp_q.push_back({v.e_instr, v.e_fpc, v.e_cause, v.e_pc});
    lat_exp = (v.e_cause == 2'd1) ? 1 : (v.e_cause == 2'd3) ? 1 + TMO : 2 + v.rd + v.rsp;
    v_exp   = (v.e_cause == 2'd1) ? 0 : v.rd + 1;
    fetch_en = 1'b1; pc_load = v.load; pc_load_addr = v.addr;
    @(negedge clk);
    fetch_en = 1'b0; pc_load = 1'b0;
    cyc = 1; hold = 0; wcyc = 0; vcnt = 0; accepted = 0; done = 0;
    while (!done && cyc < 40) begin
      imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_req_ready = 1'b0; pc_load = 1'b0;
      if (fetch_done) begin
        done = 1;
      end else begin
        if (imem_req_valid) begin
          vcnt++;
          check("req_addr", imem_req_addr, v.e_fpc);
          if (hold < v.rd) hold++;
          else begin imem_req_ready = 1'b1; accepted = 1; end
        end else if (accepted) begin
          wcyc++;
          if (v.redir && wcyc == 1) begin pc_load = 1'b1; pc_load_addr = v.raddr; end
          if (!v.no_rsp && wcyc == v.rsp) begin
            imem_rsp_valid = 1'b1; imem_rsp_err = v.err; imem_rsp_data = v.data;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    rec = exp_q.pop_front();
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_done_timeout: got none within %0d cycles expected one", cyc);
    end else begin
      check("latency", 32'(cyc), 32'(lat_exp));
      check("valid_cycles", 32'(vcnt), 32'(v_exp));
      check("instruction", instruction, rec[97:66]);
      check("fetch_pc", fetch_pc, rec[65:34]);
      check("fault_cause", 32'(fault_cause), 32'(rec[33:32]));
      check("fetch_fault", 32'(fetch_fault), 32'(rec[33:32] != 2'd0));
      check("pc", pc, rec[31:0]);
      @(negedge clk);
      check("done_pulse", 32'(fetch_done), 32'd0);
      check("back_idle", 32'(dbg_state), 32'(IDLE));
    end
  endtask

  // Reference model: outcome of one fetch from the rules, not from the FSM.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [31:0] a;
    r = v;
    a = v.load ? v.addr : model_pc;
    r.e_fpc = a;
    r.e_instr = '0;
    if (a[1:0] != 2'b00) begin
      r.e_cause = 2'd1;
      r.e_pc = a;
    end else begin
      if (v.no_rsp || (v.rd + v.rsp > TMO - 1)) r.e_cause = 2'd3;
      else if (v.err) r.e_cause = 2'd2;
      else begin r.e_cause = 2'd0; r.e_instr = v.data; end
      if (v.redir) r.e_pc = v.raddr;
      else if (r.e_cause == 2'd0) r.e_pc = a + 32'd4;
      else r.e_pc = a;
    end
    return r;
  endfunction

  initial begin
    vec_t v;
    reset_n = 1'b0; fetch_en = 1'b0; pc_load = 1'b0; pc_load_addr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = '0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_done", 32'(fetch_done), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    check("rst_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    @(negedge clk);

    //        load addr            rd rsp err nr data            rdr raddr          e_instr        e_fpc          cs  e_pc
    tv[0]  = '{0, 32'h0,           0, 1, 0, 0, 32'h0010_0093, 0, 32'h0,         32'h0010_0093, 32'h0,         0, 32'h4};
    tv[1]  = '{0, 32'h0,           5, 1, 0, 0, 32'hDEAD_BEEF, 0, 32'h0,         32'hDEAD_BEEF, 32'h4,         0, 32'h8};
    tv[2]  = '{1, 32'h102,         0, 1, 0, 0, 32'h1234_5678, 0, 32'h0,         32'h0,         32'h102,       1, 32'h102};
    tv[3]  = '{1, 32'h100,         0, 2, 0, 0, 32'h1111_1111, 0, 32'h0,         32'h1111_1111, 32'h100,       0, 32'h104};
    tv[4]  = '{0, 32'h0,           1, 1, 1, 0, 32'hFFFF_0000, 0, 32'h0,         32'h0,         32'h104,       2, 32'h104};
    tv[5]  = '{0, 32'h0,           0, 1, 0, 1, 32'h0,         0, 32'h0,         32'h0,         32'h104,       3, 32'h104};
    tv[6]  = '{1, 32'h100,         0, 3, 0, 0, 32'h2222_2222, 1, 32'h2000,      32'h2222_2222, 32'h100,       0, 32'h2000};
    tv[7]  = '{0, 32'h0,           2, 1, 0, 0, 32'h3333_3333, 0, 32'h0,         32'h3333_3333, 32'h2000,      0, 32'h2004};
    tv[8]  = '{1, 32'hFFFF_FFFC,   0, 1, 0, 0, 32'h4444_4444, 0, 32'h0,         32'h4444_4444, 32'hFFFF_FFFC, 0, 32'h0};
    tv[9]  = '{0, 32'h0,           3, 4, 0, 0, 32'h5555_5555, 0, 32'h0,         32'h5555_5555, 32'h0,         0, 32'h4};
    tv[10] = '{0, 32'h0,           3, 5, 0, 0, 32'h6666_6666, 0, 32'h0,         32'h0,         32'h4,         3, 32'h4};

    for (int i = 0; i < 11; i++) begin
      do_fetch(tv[i]);
      if (i == 5) begin
        // Stray response after a timeout must not produce a fetch_done.
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("late_rsp_done", 32'(fetch_done), 32'd0);
        check("late_rsp_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        check("late_rsp_done2", 32'(fetch_done), 32'd0);
        check("late_rsp_instr", instruction, 32'h0);
        check("late_rsp_pc", pc, 32'h104);
      end
    end

    // Redirect in IDLE without a fetch.
    pc_load = 1'b1; pc_load_addr = 32'h300;
    @(negedge clk);
    pc_load = 1'b0;
    check("idle_load_pc", pc, 32'h300);
    check("idle_load_valid", 32'(imem_req_valid), 32'd0);
    check("idle_load_done", 32'(fetch_done), 32'd0);

    // Reset asserted while waiting on a response.
    fetch_en = 1'b1; pc_load = 1'b1; pc_load_addr = 32'h40;
    @(negedge clk);
    fetch_en = 1'b0; pc_load = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("pre_rst_state", 32'(dbg_state), 32'(WAIT));
    reset_n = 1'b0;
    #1;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_addr", imem_req_addr, 32'h0);
    check("mid_rst_instr", instruction, 32'h0);
    check("mid_rst_fetch_pc", fetch_pc, 32'h0);
    check("mid_rst_cause", 32'(fault_cause), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_pc = 32'h0;
    v = '{0, 32'h0, 0, 1, 0, 0, 32'h7777_7777, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0};
    v = model(v);
    do_fetch(v);
    model_pc = v.e_pc;

    // Randomized fetches against the model.
    for (int i = 0; i < 40; i++) begin
      int kind;
      v.load = ($urandom_range(0, 3) == 0);
      v.addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
      v.rd = $urandom_range(0, 4);
      v.rsp = $urandom_range(1, 5);
      kind = $urandom_range(0, 9);
      v.no_rsp = (kind == 0);
      v.err = (kind == 1);
      v.data = $urandom;
      v.redir = ($urandom_range(0, 4) == 0);
      v.raddr = $urandom & 32'hFFFF_FFFC;
      v = model(v);
      do_fetch(v);
      model_pc = v.e_pc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
